// File: rtl/dcache_data_arb_sched_pkg.sv
// Shared definitions for the DCache data-array scheduler: requester roles,
// FSM encoding and the per-requester request record.
package dcache_arb_pkg;

  localparam int REQ_PIPE   = 0;
  localparam int REQ_REFILL = 1;
  localparam int REQ_WB     = 2;
  localparam int REQ_PROBE  = 3;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_ECC_W  = 8;
  localparam int DEF_WAYS   = 4;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  typedef enum logic [0:0] {IDLE = ST_IDLE, LOCKED = ST_LOCKED} state_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic                  write;
    logic [DEF_DATA_W-1:0] wdata;
    logic [DEF_ECC_W-1:0]  eccMask;
    logic [DEF_WAYS-1:0]   way_en;
  } req_t;

endpackage

// File: rtl/dcache_data_arb_sched_if.sv
// Requester-side and array-side bundle of the data-array scheduler.
interface dcache_data_arb_sched_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64,
  parameter int WAYS   = 4,
  parameter int BEAT_W = 3
);
  logic [N_REQ-1:0]        io_in_valid;
  logic [N_REQ-1:0]        io_in_ready;
  logic [N_REQ*ADDR_W-1:0] io_in_bits_addr;
  logic [N_REQ-1:0]        io_in_bits_write;
  logic [N_REQ*DATA_W-1:0] io_in_bits_wdata;
  logic [N_REQ*8-1:0]      io_in_bits_eccMask;
  logic [N_REQ*WAYS-1:0]   io_in_bits_way_en;
  logic                    io_out_valid;
  logic                    io_out_ready;
  logic [ADDR_W-1:0]       io_out_bits_addr;
  logic                    io_out_bits_write;
  logic [DATA_W-1:0]       io_out_bits_wdata;
  logic [7:0]              io_out_bits_eccMask;
  logic [WAYS-1:0]         io_out_bits_way_en;
  logic                    io_lock_valid;
  logic [1:0]              io_lock_owner;
  logic [BEAT_W-1:0]       io_beat;

  modport master (
    output io_in_valid, io_in_bits_addr, io_in_bits_write, io_in_bits_wdata,
           io_in_bits_eccMask, io_in_bits_way_en, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_bits_addr, io_out_bits_write,
           io_out_bits_wdata, io_out_bits_eccMask, io_out_bits_way_en,
           io_lock_valid, io_lock_owner, io_beat
  );

  modport slave (
    input  io_in_valid, io_in_bits_addr, io_in_bits_write, io_in_bits_wdata,
           io_in_bits_eccMask, io_in_bits_way_en, io_out_ready,
    output io_in_ready, io_out_valid, io_out_bits_addr, io_out_bits_write,
           io_out_bits_wdata, io_out_bits_eccMask, io_out_bits_way_en,
           io_lock_valid, io_lock_owner, io_beat
  );
endinterface

// File: rtl/dcache_data_arb_sched_starve.sv
// Per-requester starvation counter: counts consecutive denied cycles and
// raises promote once the limit is reached.
module dcache_starve_ctr #(
  parameter  int STARVE_LIMIT = 16,
  localparam int CW           = $clog2(STARVE_LIMIT) + 1
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic valid,
  input  logic fire,
  output logic promote
);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  // en is the array-side ready: a stalled array freezes all scheduler state
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (!valid || fire)    cnt_d = '0;
      else if (cnt_q < LIMIT) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign promote = (cnt_q >= LIMIT);
endmodule

// File: rtl/dcache_data_arb_sched.sv
// Data-array port scheduler: fixed priority with refill/writeback burst
// locking and starvation promotion; grant is combinational.
module dcache_data_arb_sched
  import dcache_arb_pkg::*;
#(
  parameter  int N_REQ        = 4,
  parameter  int ADDR_W       = 12,
  parameter  int DATA_W       = 64,
  parameter  int WAYS         = 4,
  parameter  int BEATS        = 8,
  parameter  int STARVE_LIMIT = 16,
  localparam int BEAT_W       = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  dcache_data_arb_sched_if.slave   io
);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  logic [N_REQ-1:0][ADDR_W-1:0] in_addr;
  logic [N_REQ-1:0][DATA_W-1:0] in_wdata;
  logic [N_REQ-1:0][7:0]        in_ecc;
  logic [N_REQ-1:0][WAYS-1:0]   in_way;
  logic [N_REQ-1:0]             valid, grant, ready, fire, promoted;
  logic [1:0]                   gidx;
  logic                         found, out_fire;

  logic [0:0]        state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  assign in_addr  = io.io_in_bits_addr;
  assign in_wdata = io.io_in_bits_wdata;
  assign in_ecc   = io.io_in_bits_eccMask;
  assign in_way   = io.io_in_bits_way_en;
  assign valid    = io.io_in_valid;

  // Grant: owner only while locked, else promoted-first then fixed priority
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    if (state_q == ST_LOCKED) begin
      gidx        = owner_q;
      grant[gidx] = valid[gidx];
    end else begin
      for (int i = 1; i < N_REQ; i++)
        if (!found && promoted[i] && valid[i]) begin found = 1'b1; gidx = 2'(i); end
      for (int i = 0; i < N_REQ; i++)
        if (!found && valid[i]) begin found = 1'b1; gidx = 2'(i); end
      grant[gidx] = found;
    end
  end

  assign ready    = grant & {N_REQ{io.io_out_ready}};
  assign fire     = valid & ready;
  assign out_fire = |fire;

  assign promoted[REQ_PIPE] = 1'b0;
  for (genvar i = 1; i < N_REQ; i++) begin : g_starve
    dcache_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_ctr (
      .clock   (clock),
      .reset   (reset),
      .en      (io.io_out_ready),
      .valid   (valid[i]),
      .fire    (fire[i]),
      .promote (promoted[i])
    );
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    beat_d  = beat_q;
    if (out_fire) begin
      if (state_q == ST_IDLE) begin
        if (BEATS > 1 && (gidx == 2'(REQ_REFILL) || gidx == 2'(REQ_WB))) begin
          state_d = ST_LOCKED;
          owner_d = gidx;
          beat_d  = BEAT_W'(1);
        end
      end else if (beat_q == LAST_BEAT) begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end else begin
        beat_d  = beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
    end
  end

  assign io.io_in_ready         = ready;
  assign io.io_out_valid        = |grant;
  assign io.io_out_bits_addr    = in_addr[gidx];
  assign io.io_out_bits_write   = io.io_in_bits_write[gidx];
  assign io.io_out_bits_wdata   = in_wdata[gidx];
  assign io.io_out_bits_eccMask = in_ecc[gidx];
  assign io.io_out_bits_way_en  = in_way[gidx];
  assign io.io_lock_valid       = (state_q == ST_LOCKED);
  assign io.io_lock_owner       = owner_q;
  assign io.io_beat             = beat_q;
endmodule

// File: tb/tb_dcache_data_arb_sched.sv
// Scenario bench for the data-array scheduler with a cycle-level reference
// model of the arbitration rules and a randomized soak.
module tb_dcache_data_arb_sched;
  import dcache_arb_pkg::*;

  logic clock, reset;
  req_t rq [4];
  logic [3:0] vld;
  logic ordy;

  bit m_locked;
  int m_owner, m_beat;
  int m_cnt [4];
  int checks, failures;

  dcache_data_arb_sched_if #(.N_REQ(4), .ADDR_W(12), .DATA_W(64), .WAYS(4), .BEAT_W(3)) io ();

  dcache_data_arb_sched #(.N_REQ(4), .ADDR_W(12), .DATA_W(64), .WAYS(4), .BEATS(8),
                          .STARVE_LIMIT(16)) dut (.clock(clock), .reset(reset), .io(io));

  initial begin clock = 1'b0; forever #5 clock = ~clock; end

  always_comb begin
    io.io_in_valid        = vld;
    io.io_out_ready       = ordy;
    io.io_in_bits_addr    = '0;
    io.io_in_bits_write   = '0;
    io.io_in_bits_wdata   = '0;
    io.io_in_bits_eccMask = '0;
    io.io_in_bits_way_en  = '0;
    for (int i = 0; i < 4; i++) begin
      io.io_in_bits_addr[i*12 +: 12]   = rq[i].addr;
      io.io_in_bits_write[i]           = rq[i].write;
      io.io_in_bits_wdata[i*64 +: 64]  = rq[i].wdata;
      io.io_in_bits_eccMask[i*8 +: 8]  = rq[i].eccMask;
      io.io_in_bits_way_en[i*4 +: 4]   = rq[i].way_en;
    end
  end

  // Index the rules would grant this cycle, -1 if none
  function automatic int exp_grant();
    if (m_locked) return vld[m_owner] ? m_owner : -1;
    for (int i = 1; i < 4; i++) if (vld[i] && m_cnt[i] >= 16) return i;
    for (int i = 0; i < 4; i++) if (vld[i]) return i;
    return -1;
  endfunction

  task automatic model_clear();
    m_locked = 0; m_owner = 0; m_beat = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  task automatic tick();
    int g;
    bit f;
    @(posedge clock);
    g = exp_grant();
    f = (g >= 0) && ordy;
    if (ordy) begin
      for (int i = 1; i < 4; i++)
        if (!vld[i] || (f && g == i)) m_cnt[i] = 0;
        else if (m_cnt[i] < 16) m_cnt[i]++;
      if (f) begin
        if (!m_locked) begin
          if (g == 1 || g == 2) begin m_locked = 1; m_owner = g; m_beat = 1; end
        end else if (m_beat == 7) begin m_locked = 0; m_beat = 0; end
        else m_beat++;
      end
    end
    #1;
  endtask

  task automatic rand_reqs();
    for (int i = 0; i < 4; i++) begin
      rq[i].addr    = 12'($urandom);
      rq[i].write   = 1'($urandom);
      rq[i].wdata   = {$urandom, $urandom};
      rq[i].eccMask = 8'($urandom);
      rq[i].way_en  = 4'($urandom);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; vld = '0; ordy = 1'b1;
    model_clear();
    rand_reqs();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; vld = '0; ordy = 1'b1;
    model_clear();
    @(negedge clock);
    checks++; if (io.io_lock_valid !== 1'b0) begin failures++; $display("FAIL reset_lock act=%b exp=0", io.io_lock_valid); end
    checks++; if (io.io_beat !== 3'd0) begin failures++; $display("FAIL reset_beat act=%0d exp=0", io.io_beat); end
    checks++; if (io.io_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid act=%b exp=0", io.io_out_valid); end
    checks++; if (io.io_in_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready act=%b exp=0000", io.io_in_ready); end
    @(posedge clock); #1 reset = 1'b1;
  endtask

  task automatic test_priority();
    do_reset();
    vld = 4'b1001;
    @(negedge clock);
    checks++; if (io.io_in_ready !== 4'b0001) begin failures++; $display("FAIL prio_ready act=%b exp=0001", io.io_in_ready); end
    checks++; if (io.io_out_bits_addr !== rq[0].addr) begin failures++; $display("FAIL prio_addr act=%h exp=%h", io.io_out_bits_addr, rq[0].addr); end
    checks++; if (io.io_out_bits_wdata !== rq[0].wdata) begin failures++; $display("FAIL prio_wdata act=%h exp=%h", io.io_out_bits_wdata, rq[0].wdata); end
    tick();
  endtask

  task automatic test_burst_lock();
    do_reset();
    vld = 4'b0010;
    @(negedge clock);
    checks++; if (io.io_in_ready !== 4'b0010) begin failures++; $display("FAIL burst_first_ready act=%b exp=0010", io.io_in_ready); end
    tick();
    vld = 4'b0011;
    for (int k = 1; k < 8; k++) begin
      @(negedge clock);
      checks++; if (io.io_in_ready !== 4'b0010) begin failures++; $display("FAIL burst_ready beat=%0d act=%b exp=0010", k, io.io_in_ready); end
      checks++; if (io.io_lock_valid !== 1'b1 || io.io_lock_owner !== 2'd1) begin failures++; $display("FAIL burst_owner act=%b/%0d exp=1/1", io.io_lock_valid, io.io_lock_owner); end
      checks++; if (io.io_beat !== 3'(k)) begin failures++; $display("FAIL burst_beat act=%0d exp=%0d", io.io_beat, k); end
      tick();
    end
    vld = 4'b0001;
    @(negedge clock);
    checks++; if (io.io_lock_valid !== 1'b0) begin failures++; $display("FAIL burst_release act=%b exp=0", io.io_lock_valid); end
    checks++; if (io.io_in_ready !== 4'b0001) begin failures++; $display("FAIL burst_after_ready act=%b exp=0001", io.io_in_ready); end
    tick();
  endtask

  task automatic test_owner_stall();
    do_reset();
    vld = 4'b0100;
    repeat (3) tick();
    vld = 4'b1000;
    repeat (4) begin
      @(negedge clock);
      checks++; if (io.io_out_valid !== 1'b0) begin failures++; $display("FAIL stall_out_valid act=%b exp=0", io.io_out_valid); end
      checks++; if (io.io_beat !== 3'd3) begin failures++; $display("FAIL stall_beat act=%0d exp=3", io.io_beat); end
      checks++; if (io.io_in_ready !== 4'b0000) begin failures++; $display("FAIL stall_ready act=%b exp=0000", io.io_in_ready); end
      tick();
    end
    vld = 4'b0100;
    for (int k = 3; k < 8; k++) begin
      @(negedge clock);
      checks++; if (io.io_in_ready !== 4'b0100 || io.io_beat !== 3'(k)) begin failures++; $display("FAIL stall_resume act=%b/%0d exp=0100/%0d", io.io_in_ready, io.io_beat, k); end
      tick();
    end
    vld = '0;
    @(negedge clock);
    checks++; if (io.io_lock_valid !== 1'b0) begin failures++; $display("FAIL stall_release act=%b exp=0", io.io_lock_valid); end
  endtask

  task automatic test_starvation();
    do_reset();
    vld = 4'b1001;
    for (int t = 0; t < 16; t++) begin
      @(negedge clock);
      checks++; if (io.io_in_ready !== 4'b0001) begin failures++; $display("FAIL starve_denied t=%0d act=%b exp=0001", t, io.io_in_ready); end
      tick();
    end
    @(negedge clock);
    checks++; if (io.io_in_ready !== 4'b1000) begin failures++; $display("FAIL starve_promote act=%b exp=1000", io.io_in_ready); end
    tick();
    @(negedge clock);
    checks++; if (io.io_in_ready !== 4'b0001) begin failures++; $display("FAIL starve_resume act=%b exp=0001", io.io_in_ready); end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    vld = 4'b0010;
    repeat (5) tick();
    ordy = 1'b0;
    repeat (3) begin
      @(negedge clock);
      checks++; if (io.io_beat !== 3'd5) begin failures++; $display("FAIL bp_beat act=%0d exp=5", io.io_beat); end
      checks++; if (io.io_in_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready act=%b exp=0000", io.io_in_ready); end
      checks++; if (io.io_out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid act=%b exp=1", io.io_out_valid); end
      tick();
    end
    ordy = 1'b1;
    for (int k = 5; k < 8; k++) begin
      @(negedge clock);
      checks++; if (io.io_in_ready !== 4'b0010 || io.io_beat !== 3'(k)) begin failures++; $display("FAIL bp_resume act=%b/%0d exp=0010/%0d", io.io_in_ready, io.io_beat, k); end
      tick();
    end
    vld = '0;
    @(negedge clock);
    checks++; if (io.io_lock_valid !== 1'b0) begin failures++; $display("FAIL bp_release act=%b exp=0", io.io_lock_valid); end
  endtask

  task automatic test_async_reset();
    do_reset();
    vld = 4'b0100;
    repeat (4) tick();
    @(negedge clock);
    checks++; if (io.io_lock_valid !== 1'b1 || io.io_beat !== 3'd4) begin failures++; $display("FAIL ar_pre act=%b/%0d exp=1/4", io.io_lock_valid, io.io_beat); end
    #2 reset = 1'b0;
    vld = 4'b0001;
    model_clear();
    #1;
    checks++; if (io.io_lock_valid !== 1'b0 || io.io_beat !== 3'd0) begin failures++; $display("FAIL ar_clear act=%b/%0d exp=0/0", io.io_lock_valid, io.io_beat); end
    checks++; if (io.io_out_valid !== 1'b1) begin failures++; $display("FAIL ar_out_valid act=%b exp=1", io.io_out_valid); end
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock);
    checks++; if (io.io_in_ready !== 4'b0001 || io.io_out_bits_addr !== rq[0].addr) begin failures++; $display("FAIL ar_after act=%b/%h exp=0001/%h", io.io_in_ready, io.io_out_bits_addr, rq[0].addr); end
    tick();
  endtask

  task automatic test_random();
    int g;
    logic [3:0] er;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) rand_reqs();
      vld[0] = ($urandom_range(0, 3) != 0);
      for (int i = 1; i < 4; i++) vld[i] = ($urandom_range(0, 2) != 0);
      ordy = ($urandom_range(0, 7) != 0);
      @(negedge clock);
      g  = exp_grant();
      er = (g >= 0 && ordy) ? 4'(1 << g) : 4'b0000;
      checks++; if (io.io_out_valid !== (g >= 0)) begin failures++; $display("FAIL rnd_out_valid n=%0d act=%b exp=%b", n, io.io_out_valid, g >= 0); end
      checks++; if (io.io_in_ready !== er) begin failures++; $display("FAIL rnd_ready n=%0d act=%b exp=%b", n, io.io_in_ready, er); end
      if (g >= 0) begin
        checks++;
        if (io.io_out_bits_addr !== rq[g].addr || io.io_out_bits_write !== rq[g].write ||
            io.io_out_bits_wdata !== rq[g].wdata || io.io_out_bits_eccMask !== rq[g].eccMask ||
            io.io_out_bits_way_en !== rq[g].way_en) begin
          failures++; $display("FAIL rnd_bits n=%0d act_addr=%h exp_addr=%h req=%0d", n, io.io_out_bits_addr, rq[g].addr, g);
        end
      end
      checks++; if (io.io_lock_valid !== m_locked || io.io_beat !== 3'(m_beat)) begin failures++; $display("FAIL rnd_lock n=%0d act=%b/%0d exp=%b/%0d", n, io.io_lock_valid, io.io_beat, m_locked, m_beat); end
      if (m_locked) begin
        checks++; if (io.io_lock_owner !== 2'(m_owner)) begin failures++; $display("FAIL rnd_owner n=%0d act=%0d exp=%0d", n, io.io_lock_owner, m_owner); end
      end
      tick();
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; vld = '0; ordy = 1'b1;
    for (int i = 0; i < 4; i++) rq[i] = '0;
    model_clear();
    test_reset();
    test_priority();
    test_burst_lock();
    test_owner_stall();
    test_starvation();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dcache_data_arb_sched.md
Name: dcache_data_arb_sched

Overview:
- Scheduler in front of the DCache data array. Shares the single array port between four requesters:
  - 0 = pipeline access
  - 1 = refill write
  - 2 = writeback read
  - 3 = probe read
- Base policy is fixed priority, with two additions:
  - burst locking, so refill and writeback beats of one line are never interleaved;
  - starvation promotion, so low-priority requesters cannot be locked out forever by pipeline traffic.
- Sits between the requester queues and the data array; the grant path has zero latency.

Parameters:
- N_REQ, 4, number of requesters (fixed port roles above)
- ADDR_W, 12, array address width
- DATA_W, 64, data beat width
- WAYS, 4, way-enable width
- BEATS, 8, beats per cache line burst
- STARVE_LIMIT, 16, consecutive denied cycles before promotion

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-low reset
- io_in_valid  in  N_REQ  request valid per requester
- io_in_ready  out  N_REQ  request accepted this cycle
- io_in_bits_addr  in  N_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- io_in_bits_write  in  N_REQ  write enable per requester
- io_in_bits_wdata  in  N_REQ*DATA_W  packed write data
- io_in_bits_eccMask  in  N_REQ*8  packed byte ECC masks
- io_in_bits_way_en  in  N_REQ*WAYS  packed way enables
- io_out_valid  out  1  array access valid
- io_out_ready  in  1  array accepts the access
- io_out_bits_addr  out  ADDR_W  granted address
- io_out_bits_write  out  1  granted write enable
- io_out_bits_wdata  out  DATA_W  granted write data
- io_out_bits_eccMask  out  8  granted ECC mask
- io_out_bits_way_en  out  WAYS  granted way enable
- io_lock_valid  out  1  a burst lock is held
- io_lock_owner  out  2  requester index holding the lock
- io_beat  out  log2(BEATS)  current beat count within the burst

Behaviour:
- Definitions:
  - fire_i = io_in_valid[i] & io_in_ready[i]
  - out_fire = io_out_valid & io_out_ready
- Grant is combinational. io_out_* muxes the granted requester's bits.
- io_in_ready[i] = grant[i] & io_out_ready.
- io_out_valid = any grant.
- FSM states: IDLE and LOCKED. Reset state is IDLE.

IDLE grant order:
- First, any promoted requester, lowest index among the promoted.
- Otherwise fixed priority 0 > 1 > 2 > 3.

Lock entry:
- In IDLE, a fire by requester 1 or 2 moves to LOCKED.
- owner := that index; beat := 1.
- If BEATS == 1, no lock is taken.

LOCKED:
- Only the owner may be granted; requesters 0 and 3 see ready=0.
- Each owner fire increments beat.
- The fire at beat == BEATS-1 returns the FSM to IDLE and sets beat := 0.
- If the owner deasserts valid mid-burst, the lock is held: io_out_valid=0 and nobody else is granted.

Starvation:
- Requesters 1..3 each have a saturating counter (width log2(STARVE_LIMIT)+1).
- The counter increments when valid & ~fire.
- It clears on fire or when valid is low.
- promoted[i] = (counter >= STARVE_LIMIT).
- Promotion is ignored while LOCKED; counters keep counting.
- Requester 0 is never promoted.

Other rules:
- io_out_ready low: no state changes and no beat advance. Grant still reflects the current valid requests.
- Reset, including mid-burst: state IDLE, beat 0, owner 0, all counters 0, io_lock_valid 0.
- Outputs during reset: io_out_valid follows the combinational IDLE grant with no promotion.

Decomposition:
- Shared package dcache_arb_pkg:
  - requester index constants REQ_PIPE=0, REQ_REFILL=1, REQ_WB=2, REQ_PROBE=3;
  - state enum {IDLE, LOCKED};
  - a req_t struct {addr, write, wdata, eccMask, way_en}.
- One natural sub-module, dcache_starve_ctr: per-requester saturating counter plus promote flag, instantiated for requesters 1..3.

Test Plan:
1. Priority: valid on 0 and 3, ready=1.
   - Requester 0 is granted.
   - io_out_bits_addr = in0 addr.
   - io_in_ready = 4'b0001.
2. Burst lock: requester 1 fires at beat 0, then requester 0 asserts valid for the next 7 cycles.
   - Requester 1 is granted all 8 beats; io_lock_owner=1; io_beat counts 1..7.
   - The FSM returns to IDLE after the 8th fire, and requester 0 is granted on the following cycle.
3. Owner stall: requester 2 locked at beat 3, valid deasserted for 4 cycles while requester 3 is valid.
   - io_out_valid=0 and io_beat holds 3 for those cycles.
   - The burst resumes when requester 2 reasserts valid.
4. Starvation: requester 0 and requester 3 valid continuously, ready=1.
   - After 16 denied cycles, requester 3 is granted exactly once.
   - Its counter then clears and requester 0 resumes.
5. Backpressure: requester 1 locked at beat 5, io_out_ready=0 for 3 cycles.
   - io_beat stays 5 and io_in_ready=0.
   - The burst completes normally afterwards.
6. Async reset asserted at beat 4 of a requester 2 burst.
   - Immediately io_lock_valid=0 and io_beat=0.
   - After release with requester 0 valid, requester 0 is granted.
